// File: rtl/rr_stream_mux_2x1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux_2x1_pkg
// Brief    : Shared state and source-index encodings for rr_stream_mux_2x1.
// Revision : 1.0
// ============================================================================
package rr_stream_mux_2x1_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_stream_mux_2x1_mux.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_w
// Brief    : Generic WIDTH-bit combinational 2:1 mux, select by source index.
// Revision : 1.0
// ============================================================================
module mux_2x1_w
    import rr_stream_mux_2x1_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = (i_sel == SRC1) ? i_in1 : i_in0;

endmodule
`default_nettype wire

// File: rtl/rr_stream_mux_2x1.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux_2x1
// Brief    : Two-input round-robin stream merge with packet lock and a
//            registered output stage.
// Revision : 1.0
// ============================================================================
module rr_stream_mux_2x1
    import rr_stream_mux_2x1_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FIRST_PRI = 0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,

    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    localparam logic c_first_pri = (FIRST_PRI != 0) ? SRC1 : SRC0;

    state_e           r_state;
    logic             r_prio;
    logic             r_lock_src;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_src;

    logic             w_ld;
    logic             w_sel;
    logic             w_sel_valid;
    logic             w_xfer;
    logic [WIDTH:0]   w_mux_y;
    logic             w_sel_last;

    assign w_ld = !r_out_valid || out_ready;

    // A held lock wins outright; otherwise an uncontested source is served
    // regardless of prio, and prio only breaks ties.
    always_comb begin
        w_sel = r_prio;
        if (r_state == ST_LOCKED) begin
            w_sel = r_lock_src;
        end else if (in0_valid && !in1_valid) begin
            w_sel = SRC0;
        end else if (in1_valid && !in0_valid) begin
            w_sel = SRC1;
        end
    end

    assign w_sel_valid = (w_sel == SRC1) ? in1_valid : in0_valid;
    assign w_xfer      = w_ld && w_sel_valid;
    assign in0_ready   = w_ld && (w_sel == SRC0);
    assign in1_ready   = w_ld && (w_sel == SRC1);

    mux_2x1_w #(
        .WIDTH (WIDTH + 1)
    ) u_mux (
        .i_sel (w_sel),
        .i_in0 ({in0_last, in0_data}),
        .i_in1 ({in1_last, in1_data}),
        .o_y   (w_mux_y)
    );

    assign w_sel_last = w_mux_y[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prio      <= c_first_pri;
            r_lock_src  <= SRC0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= SRC0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_y[WIDTH-1:0];
            r_out_last  <= w_sel_last;
            r_out_src   <= w_sel;
            case (r_state)
                ST_IDLE: begin
                    if (!w_sel_last) begin
                        r_state    <= ST_LOCKED;
                        r_lock_src <= w_sel;
                    end else begin
                        r_prio <= ~w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (w_sel_last) begin
                        r_state <= ST_IDLE;
                        r_prio  <= ~r_lock_src;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end else if (w_ld) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_mux_2x1
// Brief    : Self-checking bench for rr_stream_mux_2x1 against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_rr_stream_mux_2x1;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in0_valid = 1'b0, in0_last = 1'b0, in0_ready;
    logic             in1_valid = 1'b0, in1_last = 1'b0, in1_ready;
    logic [WIDTH-1:0] in0_data = '0, in1_data = '0;
    logic             out_valid, out_last, out_src;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: arbitration rules applied to whole packets.
    bit               m_locked, m_lsrc, m_prio, m_ov, m_ol, m_os, m_xf, m_sel;
    logic [WIDTH-1:0] m_od;

    logic [WIDTH:0] q0[$], q1[$];     // {last, data} beats waiting per source
    logic [WIDTH:0] obs_q[$], exp_q[$]; // {src, data} of delivered beats

    always #5 clk = ~clk;

    rr_stream_mux_2x1 #(.WIDTH(WIDTH), .FIRST_PRI(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_lsrc = 0; m_prio = 0;
        m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_xf = 0; m_sel = 0;
    endtask

    task automatic drive();
        in0_valid = (q0.size() > 0);
        in1_valid = (q1.size() > 0);
        if (in0_valid) {in0_last, in0_data} = q0[0];
        else begin in0_data = 8'($urandom); in0_last = 1'($urandom); end
        if (in1_valid) {in1_last, in1_data} = q1[0];
        else begin in1_data = 8'($urandom); in1_last = 1'($urandom); end
    endtask

    // One clock: predict grant/readies from current inputs, then the output register.
    task automatic step();
        bit ld, v, l;
        logic [WIDTH-1:0] d;
        #1;
        ld = !m_ov || out_ready;
        if (m_locked)                      m_sel = m_lsrc;
        else if (in0_valid && !in1_valid)  m_sel = 1'b0;
        else if (in1_valid && !in0_valid)  m_sel = 1'b1;
        else                               m_sel = m_prio;
        check_eq("in0_ready", in0_ready, ld && !m_sel);
        check_eq("in1_ready", in1_ready, ld && m_sel);
        v = m_sel ? in1_valid : in0_valid;
        d = m_sel ? in1_data  : in0_data;
        l = m_sel ? in1_last  : in0_last;
        m_xf = ld && v;
        @(posedge clk);
        #1;
        if (m_xf) begin
            m_ov = 1; m_od = d; m_ol = l; m_os = m_sel;
            if (l) begin m_locked = 0; m_prio = !m_sel; end
            else begin m_locked = 1; m_lsrc = m_sel; end
        end else if (ld) begin
            m_ov = 0;
        end
        check_eq("out_valid", out_valid, m_ov);
        check_eq("out_data",  out_data,  m_od);
        check_eq("out_last",  out_last,  m_ol);
        check_eq("out_src",   out_src,   m_os);
        if (m_xf) begin
            if (m_sel) void'(q1.pop_front());
            else       void'(q0.pop_front());
            obs_q.push_back({out_src, out_data});
        end
    endtask

    task automatic run(input int max_cyc, output int cycles);
        cycles = 0;
        while ((q0.size() > 0 || q1.size() > 0) && cycles < max_cyc) begin
            drive();
            step();
            cycles++;
        end
        check_eq("drain", q0.size() + q1.size(), 0);
    endtask

    task automatic compare_obs(input string tag);
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  open_valid, open_src;
        logic [WIDTH-1:0] cnt0, cnt1;

        model_reset();
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data",  out_data,  0);
        check_eq("rst_out_last",  out_last,  0);
        check_eq("rst_out_src",   out_src,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: source 0 holds the grant.
        repeat (5) begin drive(); step(); end

        // Contested single-beat packets alternate.
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'(8'h10 + i)});
            q1.push_back({1'b1, 8'(8'h20 + i)});
            exp_q.push_back({1'b0, 8'(8'h10 + i)});
            exp_q.push_back({1'b1, 8'(8'h20 + i)});
        end
        run(20, cyc);
        check_eq("alt_cycles", cyc, 8);
        compare_obs("alt_seq");

        // Multi-beat packet on source 0 locks out source 1.
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
        q1.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hA2}); exp_q.push_back({1'b1, 8'hB0});
        run(20, cyc);
        compare_obs("lock_seq");

        // Back-pressure holds 0x55 and blocks both inputs.
        q0.push_back({1'b1, 8'h55});
        run(5, cyc);
        obs_q.delete();
        out_ready = 1'b0;
        q0.push_back({1'b1, 8'h56});
        q1.push_back({1'b1, 8'h66});
        repeat (4) begin
            drive();
            step();
            check_eq("bp_hold_data", out_data, 8'h55);
            check_eq("bp_hold_src",  out_src,  0);
        end
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h66});
        exp_q.push_back({1'b0, 8'h56});
        run(10, cyc);
        compare_obs("bp_seq");

        // Single-source traffic, then a contested cycle goes to source 0.
        for (int i = 0; i < 4; i++) begin
            q1.push_back({1'b1, 8'(8'h30 + i)});
            exp_q.push_back({1'b1, 8'(8'h30 + i)});
        end
        run(10, cyc);
        check_eq("solo_cycles", cyc, 4);
        q0.push_back({1'b1, 8'h70}); q1.push_back({1'b1, 8'h71});
        exp_q.push_back({1'b0, 8'h70}); exp_q.push_back({1'b1, 8'h71});
        run(10, cyc);
        compare_obs("solo_seq");

        // Reset while locked on source 1 with a beat in flight.
        q1.push_back({1'b0, 8'hC0}); q1.push_back({1'b0, 8'hC1});
        drive();
        step();
        check_eq("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_data",  out_data,  0);
        model_reset();
        q0.delete(); q1.delete(); obs_q.delete();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        q0.push_back({1'b1, 8'h80}); q1.push_back({1'b1, 8'h90});
        exp_q.push_back({1'b0, 8'h80}); exp_q.push_back({1'b1, 8'h90});
        run(10, cyc);
        compare_obs("post_rst_seq");

        // Randomized traffic: random packet lengths, gaps and back-pressure.
        cnt0 = 8'h40; cnt1 = 8'hC0;
        open_valid = 0; open_src = 0;
        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 4 && $urandom_range(3) == 0) begin
                q0.push_back({1'($urandom_range(2) == 0), cnt0}); cnt0++;
            end
            if (q1.size() < 4 && $urandom_range(3) == 0) begin
                q1.push_back({1'($urandom_range(2) == 0), cnt1}); cnt1++;
            end
            out_ready = ($urandom_range(9) < 7);
            drive();
            step();
            if (m_xf) begin
                if (open_valid) check_eq("pkt_atomic", out_src, open_src);
                open_valid = !out_last;
                open_src   = out_src;
            end
        end
        obs_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
